// File: rtl/t05_mem_arbiter.sv
// Single-port memory arbiter: the stage owning the pipeline state wins, others are served round-robin.
// Optional abort on a stalled memory when T05_ARB_TIMEOUT_EN is defined (TIMEOUT parameter and timeout_err).
module t05_mem_arbiter #(
   parameter int NREQ = 4,
   parameter int AW   = 32,
   parameter int DW   = 32
`ifdef T05_ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 255
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        state_reg,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   we,
   input  logic [NREQ*AW-1:0] addr,
   input  logic [NREQ*DW-1:0] wdata,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   ack,
   output logic [DW-1:0]     rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [AW-1:0]     mem_addr,
   output logic [DW-1:0]     mem_wdata,
   input  logic              mem_ack,
   input  logic [DW-1:0]     mem_rdata,
   output logic              busy,
   output logic              timeout_err
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   // Handshake: a requester holds req (with we/addr/wdata) until its one-cycle ack;
   // the arbiter holds mem_req and the mem_* fields until the memory returns mem_ack.
   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   rr_ptr;
   int              owner_idx;
   logic            owner_hit, owner_ok;
   logic [NREQ-1:0] win_oh;
   logic            win_any;
   logic [IW-1:0]   win_idx;
   logic            sel_we;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_wdata;
   logic            take, fin_ok, fin_tmo, tmo_hit;

   always_comb begin
      owner_idx = 0;
      owner_hit = 1'b0;
      case (state_reg)
         4'd1:       begin owner_idx = 0; owner_hit = 1'b1; end
         4'd2, 4'd3: begin owner_idx = 1; owner_hit = 1'b1; end
         4'd4:       begin owner_idx = 2; owner_hit = 1'b1; end
         4'd5, 4'd6: begin owner_idx = 3; owner_hit = 1'b1; end
         default:    begin owner_idx = 0; owner_hit = 1'b0; end
      endcase
      owner_ok = owner_hit && (owner_idx < NREQ);
   end

   // Owner first; otherwise the first request found after the last winner.
   always_comb begin
      win_oh  = '0;
      win_any = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (owner_ok && (owner_idx == i) && req[i]) begin
            win_oh[i] = 1'b1;
            win_any   = 1'b1;
         end
      end
      for (int k = 1; k <= NREQ; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!win_any && req[i] && (((int'(rr_ptr) + k) % NREQ) == i)) begin
               win_oh[i] = 1'b1;
               win_any   = 1'b1;
            end
         end
      end
   end

   always_comb begin
      win_idx   = '0;
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_oh[i]) begin
            win_idx   = IW'(i);
            sel_we    = we[i];
            sel_addr  = addr[i*AW +: AW];
            sel_wdata = wdata[i*DW +: DW];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (win_any) state_nxt = S_BUSY;
         S_BUSY:  if (mem_ack || tmo_hit) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy    = (state == S_BUSY);
      take    = (state == S_IDLE) && win_any;
      fin_ok  = (state == S_BUSY) && mem_ack;
      fin_tmo = (state == S_BUSY) && !mem_ack && tmo_hit;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr    <= IW'(NREQ - 1);
         gnt       <= '0;
         ack       <= '0;
         rdata     <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         ack <= '0;
         if (take) begin
            gnt       <= win_oh;
            rr_ptr    <= win_idx;
            mem_req   <= 1'b1;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
         end else if (fin_ok || fin_tmo) begin
            gnt     <= '0;
            mem_req <= 1'b0;
            ack     <= gnt;
            rdata   <= fin_ok ? mem_rdata : '0;
         end
      end
   end

`ifdef T05_ARB_TIMEOUT_EN
   localparam int CW = (TIMEOUT > 255) ? 16 : 8;
   localparam logic [CW-1:0] TMO_VAL = CW'(TIMEOUT);

   logic [CW-1:0] tmo_cnt;

   assign tmo_hit = (tmo_cnt == TMO_VAL);

   // mem_ack in the limit cycle wins, so the counter only advances on silent cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt     <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (take)
            tmo_cnt <= '0;
         else if (busy && !mem_ack && !tmo_hit)
            tmo_cnt <= tmo_cnt + 1'b1;
         if (fin_tmo)
            timeout_err <= 1'b1;
      end
   end
`else
   assign tmo_hit     = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_t05_mem_arbiter.sv
// Directed bench for t05_mem_arbiter: transaction-level model checked every cycle plus literal checks.
module tb_t05_mem_arbiter;

`ifdef T05_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
  localparam int TMO    = 5;
`else
  localparam bit TMO_EN = 1'b0;
  localparam int TMO    = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   state_reg = 4'd0;
  logic [3:0]   req = 4'd0;
  logic [3:0]   we = 4'd0;
  logic [127:0] addr = '0;
  logic [127:0] wdata = '0;
  logic [3:0]   gnt, ack;
  logic [31:0]  rdata;
  logic         mem_req, mem_we;
  logic [31:0]  mem_addr, mem_wdata;
  logic         mem_ack = 1'b0;
  logic [31:0]  mem_rdata = '0;
  logic         busy, timeout_err;

  t05_mem_arbiter #(
    .NREQ(4), .AW(32), .DW(32)
`ifdef T05_ARB_TIMEOUT_EN
    , .TIMEOUT(TMO)
`endif
  ) dut (
    .clk(clk), .rst(rst), .state_reg(state_reg), .req(req), .we(we),
    .addr(addr), .wdata(wdata), .gnt(gnt), .ack(ack), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // ---------------- memory responder ----------------
  int          lat = 1;
  bit          rd_fixed_en = 1'b0;
  logic [31:0] rd_fixed = '0;
  int          mcyc = 0;

  initial forever begin
    @(posedge clk);
    #1;
    if (rst) begin
      mcyc = 0;
      mem_ack = 1'b0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
      mcyc = 0;
    end else if (mem_req) begin
      mcyc++;
      if (lat != 0 && mcyc == lat) begin
        mem_ack = 1'b1;
        mem_rdata = rd_fixed_en ? rd_fixed : (mem_addr ^ 32'h5A5A_5A5A);
      end
    end else begin
      mcyc = 0;
    end
  end

  // ---------------- behavioural model ----------------
  int owner_tab [16] = '{-1, 0, 1, 1, 2, 3, 3, -1, -1, -1, -1, -1, -1, -1, -1, -1};

  function automatic int pick(input logic [3:0] r, input logic [3:0] s, input int last);
    int own;
    own = owner_tab[s];
    if (own >= 0 && ((r >> own) & 4'd1) != 4'd0) return own;
    for (int k = 1; k <= 4; k++) begin
      int j;
      j = (last + k) % 4;
      if (((r >> j) & 4'd1) != 4'd0) return j;
    end
    return -1;
  endfunction

  logic        m_busy = 1'b0, m_req = 1'b0, m_we = 1'b0, m_err = 1'b0;
  logic [3:0]  m_gnt = '0, m_ack = '0;
  logic [31:0] m_rdata = '0, m_addr = '0, m_wdata = '0;
  int          m_w = 0, m_last = 3, m_cnt = 0, pick_now;

  always_comb pick_now = pick(req, state_reg, m_last);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_req <= 1'b0; m_we <= 1'b0; m_err <= 1'b0;
      m_gnt <= '0; m_ack <= '0; m_rdata <= '0; m_addr <= '0; m_wdata <= '0;
      m_w <= 0; m_last <= 3; m_cnt <= 0;
    end else begin
      m_ack <= '0;
      if (!m_busy) begin
        if (pick_now >= 0) begin
          m_busy  <= 1'b1;
          m_w     <= pick_now;
          m_last  <= pick_now;
          m_gnt   <= 4'b0001 << pick_now;
          m_req   <= 1'b1;
          m_we    <= 1'((we >> pick_now) & 4'd1);
          m_addr  <= 32'(addr >> (32 * pick_now));
          m_wdata <= 32'(wdata >> (32 * pick_now));
          m_cnt   <= 0;
        end
      end else if (mem_ack) begin
        m_busy <= 1'b0; m_gnt <= '0; m_req <= 1'b0;
        m_ack <= 4'b0001 << m_w;
        m_rdata <= mem_rdata;
      end else if (TMO_EN && m_cnt == TMO) begin
        m_busy <= 1'b0; m_gnt <= '0; m_req <= 1'b0;
        m_ack <= 4'b0001 << m_w;
        m_rdata <= '0;
        m_err <= 1'b1;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0, n_fail = 0, cyc_n = 0, n;
  logic [3:0] prev_gnt = '0;
  int g_idx[$], g_cyc[$];
  int exp3 [6] = '{0, 1, 3, 0, 1, 3};
  bit auto_rel = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic cmp_cycle();
    chk("gnt", gnt, m_gnt);
    chk("ack", ack, m_ack);
    chk("busy", busy, m_busy);
    chk("mem_req", mem_req, m_req);
    chk("timeout_err", timeout_err, m_err);
    if (m_req) begin
      chk("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (m_ack != 4'd0) chk("rdata", rdata, m_rdata);
    if (gnt != 4'd0 && prev_gnt == 4'd0)
      for (int i = 0; i < 4; i++)
        if (((gnt >> i) & 4'd1) != 4'd0) begin
          g_idx.push_back(i);
          g_cyc.push_back(cyc_n);
        end
    prev_gnt = gnt;
    cyc_n++;
  endtask

  // Returns just after the next rising edge (+2), with inputs free to change.
  task automatic step();
    @(negedge clk);
    cmp_cycle();
    @(posedge clk);
    #2;
    if (auto_rel) req = req & ~ack;
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic wait_ack(input int i, output int cnt);
    cnt = 0;
    while (((ack >> i) & 4'd1) == 4'd0 && cnt < 40) begin
      step();
      cnt++;
    end
    chk("ack_seen", (ack >> i) & 4'd1, 1);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      addr[32*i +: 32]  = 32'h1000 * (i + 1);
      wdata[32*i +: 32] = 32'hA000_0000 + i;
    end
    steps(3);
    rst = 1'b0;
    chk("rst_gnt", gnt, 0);
    chk("rst_ack", ack, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_timeout_err", timeout_err, 0);

    // single read
    state_reg = 4'd1; addr[31:0] = 32'h10; we = 4'b0000;
    lat = 3; rd_fixed_en = 1'b1; rd_fixed = 32'hDEAD_BEEF; auto_rel = 1'b1;
    req = 4'b0001;
    step();
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_mem_addr", mem_addr, 32'h10);
    chk("t1_mem_we", mem_we, 0);
    wait_ack(0, n);
    chk("t1_ack_latency", n, 3);
    chk("t1_rdata", rdata, 32'hDEAD_BEEF);
    step();
    chk("t1_idle_gnt", gnt, 0);

    // owner priority
    rd_fixed_en = 1'b0; lat = 1; auto_rel = 1'b0;
    g_idx.delete(); g_cyc.delete();
    state_reg = 4'd4; req = 4'b1111;
    steps(12);
    chk("t2_grants", g_idx.size(), 6);
    foreach (g_idx[i]) chk("t2_owner", g_idx[i], 2);
    req = 4'b0000;
    steps(3);

    // round-robin from reset pointer
    apply_reset();
    g_idx.delete(); g_cyc.delete();
    state_reg = 4'd0; req = 4'b1011;
    steps(12);
    for (int i = 0; i < 6; i++)
      chk("t3_order", (i < g_idx.size()) ? g_idx[i] : -1, exp3[i]);
    for (int i = 1; i < g_cyc.size(); i++)
      chk("t3_gap", g_cyc[i] - g_cyc[i-1], 2);
    req = 4'b0000;
    steps(3);

    // hold and no-abort
    auto_rel = 1'b1; lat = 4;
    state_reg = 4'd1; we = 4'b0010;
    addr[63:32] = 32'h200; wdata[63:32] = 32'h1234_5678;
    req = 4'b0010;
    step();
    chk("t4_gnt", gnt, 4'b0010);
    chk("t4_mem_we", mem_we, 1);
    chk("t4_mem_wdata", mem_wdata, 32'h1234_5678);
    state_reg = 4'd5; req = 4'b0000;
    addr[63:32] = 32'h300; wdata[63:32] = 32'h0;
    step();
    chk("t4_hold_addr", mem_addr, 32'h200);
    chk("t4_hold_req", mem_req, 1);
    wait_ack(1, n);
    chk("t4_ack_latency", n, 3);
    chk("t4_rdata", rdata, 32'h5A5A_585A);
    we = 4'b0000;
    steps(2);

    // reset mid-busy
    auto_rel = 1'b0; lat = 0;
    state_reg = 4'd0; req = 4'b1111;
    step();
    chk("t5_gnt", gnt, 4'b0100);
    steps(2);
    #1 rst = 1'b1;
    #1;
    chk("t5_async_gnt", gnt, 0);
    chk("t5_async_mem_req", mem_req, 0);
    chk("t5_async_ack", ack, 0);
    chk("t5_async_busy", busy, 0);
    steps(2);
    lat = 1;
    rst = 1'b0;
    step();
    chk("t5_first_gnt", gnt, 4'b0001);
    req = 4'b0000;
    steps(3);

`ifdef T05_ARB_TIMEOUT_EN
    // timeout abort, then normal service
    auto_rel = 1'b1; lat = 0;
    state_reg = 4'd4; req = 4'b0100;
    step();
    chk("t6_gnt", gnt, 4'b0100);
    wait_ack(2, n);
    chk("t6_abort_latency", n, 6);
    chk("t6_rdata", rdata, 0);
    chk("t6_err", timeout_err, 1);
    lat = 1; rd_fixed_en = 1'b1; rd_fixed = 32'hCAFE_F00D;
    state_reg = 4'd1; req = 4'b0001;
    step();
    chk("t6_next_gnt", gnt, 4'b0001);
    wait_ack(0, n);
    chk("t6_next_latency", n, 1);
    chk("t6_next_rdata", rdata, 32'hCAFE_F00D);
    chk("t6_err_sticky", timeout_err, 1);
    steps(2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
